// File: rtl/controller_perf_pkg.sv
// controller_perf_pkg
//   Shared constants for the multi-section performance counter.
//   - Per-section word offsets (read and write views of the same 4-word window)
//   - STATUS word bit positions
//   - Control bit positions inside writedata
package controller_perf_pkg;

  // Read view of a section's 4-word window.
  typedef enum logic [1:0] {
    OFS_TIME_LO = 2'd0,
    OFS_TIME_HI = 2'd1,
    OFS_EVENT   = 2'd2,
    OFS_STATUS  = 2'd3
  } rd_ofs_e;

  // Write view of the same window.
  typedef enum logic [1:0] {
    OFS_STOP = 2'd0,
    OFS_GO   = 2'd1,
    OFS_NONE = 2'd2,
    OFS_CTRL = 2'd3
  } wr_ofs_e;

  // STATUS word layout: {30'b0, overflow, running}
  localparam int unsigned STATUS_RUNNING_BIT  = 0;
  localparam int unsigned STATUS_OVERFLOW_BIT = 1;

  // writedata bit that clears sticky overflow on a CTRL write.
  localparam int unsigned CTRL_CLR_OVF_BIT = 0;
  // writedata bit that turns a section-0 STOP into a global reset.
  localparam int unsigned GLOBAL_RESET_BIT = 0;

endpackage

// File: rtl/controller_perf_section.sv
// controller_perf_section
//   State for one timed section: time counter, event counter, running flag,
//   sticky overflow flag and the high-half snapshot of the time counter.
// Ports:
//   clk_i, reset_i   clock, synchronous active-high reset
//   clr_all_i        global reset strobe (clears all state, beats increments)
//   en_i             global enable; nothing counts while low
//   stop_i, go_i     section STOP / GO strobes (never both at once)
//   clr_ovf_i        clear sticky overflow
//   snap_i           capture time[TIME_WIDTH-1:32] into the snapshot
//   time_lo_o        time counter bits 31:0
//   snap_o           snapshot register
//   event_o          event counter
//   running_o        running flag
//   overflow_o       sticky overflow flag
module controller_perf_section #(
  parameter int TIME_WIDTH  = 64,
  parameter int EVENT_WIDTH = 32,
  parameter int SATURATE    = 0
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   clr_all_i,
  input  logic                   en_i,
  input  logic                   stop_i,
  input  logic                   go_i,
  input  logic                   clr_ovf_i,
  input  logic                   snap_i,
  output logic [31:0]            time_lo_o,
  output logic [TIME_WIDTH-33:0] snap_o,
  output logic [EVENT_WIDTH-1:0] event_o,
  output logic                   running_o,
  output logic                   overflow_o
);

  logic [TIME_WIDTH-1:0]  time_q,     time_d;
  logic [EVENT_WIDTH-1:0] event_q,    event_d;
  logic [TIME_WIDTH-33:0] snap_q,     snap_d;
  logic                   running_q,  running_d;
  logic                   overflow_q, overflow_d;
  logic                   ovf_set;

  always_comb begin
    time_d     = time_q;
    event_d    = event_q;
    ovf_set    = 1'b0;
    running_d  = running_q;
    snap_d     = snap_q;

    // running_q is registered, so the GO cycle itself never counts time.
    if (en_i && running_q) begin
      if (&time_q) begin
        ovf_set = 1'b1;
        time_d  = (SATURATE != 0) ? time_q : '0;
      end else begin
        time_d = time_q + TIME_WIDTH'(1);
      end
    end

    if (en_i && go_i) begin
      if (&event_q) begin
        ovf_set = 1'b1;
        event_d = (SATURATE != 0) ? event_q : '0;
      end else begin
        event_d = event_q + EVENT_WIDTH'(1);
      end
    end

    if (stop_i) begin
      running_d = 1'b0;
    end else if (go_i) begin
      running_d = 1'b1;
    end

    // A new overflow wins over a clear in the same cycle.
    overflow_d = ovf_set | (overflow_q & ~clr_ovf_i);

    // Captured from the pre-increment value, matching the low half sampled
    // into readdata on the same edge.
    if (snap_i) begin
      snap_d = time_q[TIME_WIDTH-1:32];
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i || clr_all_i) begin
      time_q     <= '0;
      event_q    <= '0;
      snap_q     <= '0;
      running_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      time_q     <= time_d;
      event_q    <= event_d;
      snap_q     <= snap_d;
      running_q  <= running_d;
      overflow_q <= overflow_d;
    end
  end

  assign time_lo_o  = time_q[31:0];
  assign snap_o     = snap_q;
  assign event_o    = event_q;
  assign running_o  = running_q;
  assign overflow_o = overflow_q;

endmodule

// File: rtl/controller_perf_counter_multi.sv
// controller_perf_counter_multi
//   Avalon-MM slave with NUM_SECTIONS independently started/stopped timed
//   sections. Section s occupies words 4s..4s+3.
// Ports:
//   clk            sole clock, rising edge
//   reset          synchronous active-high reset
//   address        word address [AW-1:0]
//   begintransfer  first-cycle qualifier for write/read
//   write, read    transfer requests
//   writedata      32-bit write data
//   readdata       registered 32-bit read data (1-cycle latency, always updating)
module controller_perf_counter_multi
  import controller_perf_pkg::*;
#(
  parameter  int NUM_SECTIONS = 2,
  parameter  int TIME_WIDTH   = 64,
  parameter  int EVENT_WIDTH  = 32,
  parameter  int SATURATE     = 0,
  localparam int AW           = $clog2(NUM_SECTIONS) + 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] address,
  input  logic          begintransfer,
  input  logic          write,
  input  logic          read,
  input  logic [31:0]   writedata,
  output logic [31:0]   readdata
);

  logic        wr_stb, rd_stb;
  int unsigned sec;
  rd_ofs_e     rofs;
  wr_ofs_e     wofs;
  logic        go0, global_reset, global_enable;
  logic [31:0] readdata_q, readdata_d;
  logic [30:0] unused_wdata;

  assign wr_stb = write & begintransfer;
  assign rd_stb = read & begintransfer;
  assign sec    = 32'(address) >> 2;
  assign rofs   = rd_ofs_e'(address[1:0]);
  assign wofs   = wr_ofs_e'(address[1:0]);

  assign go0           = wr_stb && (sec == 0) && (wofs == OFS_GO);
  assign global_reset  = wr_stb && (sec == 0) && (wofs == OFS_STOP) && writedata[GLOBAL_RESET_BIT];

  logic [NUM_SECTIONS-1:0] running_w;
  assign global_enable = running_w[0] | go0;

  // OR-chain of per-section read words; unselected sections contribute 0,
  // so unmapped addresses fall out as 0.
  logic [NUM_SECTIONS:0][31:0] rd_acc;
  assign rd_acc[0] = '0;

  for (genvar s = 0; s < NUM_SECTIONS; s++) begin : g_sec
    localparam int unsigned SIDX = s;

    logic                   sel;
    logic [31:0]            time_lo;
    logic [TIME_WIDTH-33:0] snap;
    logic [EVENT_WIDTH-1:0] evt;
    logic                   overflow;
    logic [31:0]            word;

    assign sel = (sec == SIDX);

    controller_perf_section #(
      .TIME_WIDTH  (TIME_WIDTH),
      .EVENT_WIDTH (EVENT_WIDTH),
      .SATURATE    (SATURATE)
    ) u_sec (
      .clk_i      (clk),
      .reset_i    (reset),
      .clr_all_i  (global_reset),
      .en_i       (global_enable),
      .stop_i     (wr_stb && sel && (wofs == OFS_STOP)),
      .go_i       (wr_stb && sel && (wofs == OFS_GO)),
      .clr_ovf_i  (wr_stb && sel && (wofs == OFS_CTRL) && writedata[CTRL_CLR_OVF_BIT]),
      .snap_i     (rd_stb && sel && (rofs == OFS_TIME_LO)),
      .time_lo_o  (time_lo),
      .snap_o     (snap),
      .event_o    (evt),
      .running_o  (running_w[s]),
      .overflow_o (overflow)
    );

    always_comb begin
      word = '0;
      if (sel) begin
        case (rofs)
          OFS_TIME_LO: word = time_lo;
          OFS_TIME_HI: word = 32'(snap);
          OFS_EVENT:   word = 32'(evt);
          default: begin
            word[STATUS_RUNNING_BIT]  = running_w[s];
            word[STATUS_OVERFLOW_BIT] = overflow;
          end
        endcase
      end
    end

    assign rd_acc[s+1] = rd_acc[s] | word;
  end

  assign readdata_d = rd_acc[NUM_SECTIONS];

  always_ff @(posedge clk) begin
    if (reset) begin
      readdata_q <= '0;
    end else begin
      readdata_q <= readdata_d;
    end
  end

  assign readdata     = readdata_q;
  assign unused_wdata = writedata[31:1];

endmodule

// File: tb/tb_controller_perf_counter_multi.sv
// Directed bench: two instances share stimulus, differing only in SATURATE.
// Both use NUM_SECTIONS=3 (AW=4, words 12..15 unmapped), TIME_WIDTH=40,
// EVENT_WIDTH=4. Inputs change on the falling edge; readdata is checked on
// the falling edge after the rising edge that registered it.
module tb_controller_perf_counter_multi;

  localparam int NS = 3;
  localparam int TW = 40;
  localparam int EW = 4;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] address;
  logic          begintransfer;
  logic          write;
  logic          read;
  logic [31:0]   writedata;
  logic [31:0]   rd0, rd1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  controller_perf_counter_multi #(
    .NUM_SECTIONS (NS),
    .TIME_WIDTH   (TW),
    .EVENT_WIDTH  (EW),
    .SATURATE     (0)
  ) dut0 (
    .clk           (clk),
    .reset         (reset),
    .address       (address),
    .begintransfer (begintransfer),
    .write         (write),
    .read          (read),
    .writedata     (writedata),
    .readdata      (rd0)
  );

  controller_perf_counter_multi #(
    .NUM_SECTIONS (NS),
    .TIME_WIDTH   (TW),
    .EVENT_WIDTH  (EW),
    .SATURATE     (1)
  ) dut1 (
    .clk           (clk),
    .reset         (reset),
    .address       (address),
    .begintransfer (begintransfer),
    .write         (write),
    .read          (read),
    .writedata     (writedata),
    .readdata      (rd1)
  );

  // e0: expected from the wrapping instance, e1: from the saturating one.
  task automatic chk(input string tag, input logic [31:0] e0, input logic [31:0] e1);
    checks++;
    assert (rd0 === e0) else begin
      failures++;
      $error("FAIL %s wrap: observed=%0h expected=%0h", tag, rd0, e0);
    end
    checks++;
    assert (rd1 === e1) else begin
      failures++;
      $error("FAIL %s sat: observed=%0h expected=%0h", tag, rd1, e1);
    end
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [31:0] d);
    address       = a;
    writedata     = d;
    write         = 1'b1;
    begintransfer = 1'b1;
    @(negedge clk);
    write         = 1'b0;
    begintransfer = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a);
    address       = a;
    read          = 1'b1;
    begintransfer = 1'b1;
    @(negedge clk);
    read          = 1'b0;
    begintransfer = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset         = 1'b1;
    address       = '0;
    begintransfer = 1'b0;
    write         = 1'b0;
    read          = 1'b0;
    writedata     = '0;
    idle(2);
    reset = 1'b0;

    // Reset state
    chk("reset_readdata", 32'd0, 32'd0);
    rd(4'd3);  chk("reset_status0", 32'd0, 32'd0);
    rd(4'd0);  chk("reset_time0", 32'd0, 32'd0);

    // GO s0, ten clock periods until the STOP edge: the GO edge does not
    // count, the nine idle edges and the STOP edge do -> 10.
    wr(4'd1, 32'd0);
    idle(9);
    wr(4'd0, 32'd0);
    rd(4'd0);  chk("s0_time_lo", 32'd10, 32'd10);
    rd(4'd2);  chk("s0_event", 32'd1, 32'd1);
    rd(4'd3);  chk("s0_status_stopped", 32'd0, 32'd0);
    rd(4'd1);  chk("s0_time_hi", 32'd0, 32'd0);

    // GO s1 while s0 stopped: no global enable, so no time and no event.
    wr(4'd5, 32'd0);
    idle(20);
    rd(4'd4);  chk("s1_time_gated", 32'd0, 32'd0);
    rd(4'd6);  chk("s1_event_gated", 32'd0, 32'd0);
    rd(4'd7);  chk("s1_status_running", 32'd1, 32'd1);
    // GO s0: enable rises on that edge, so s1 counts it plus 4 idle -> 5;
    // s0 resumes at 10 and gains 5 more before its read edge -> 15.
    wr(4'd1, 32'd0);
    idle(4);
    rd(4'd4);  chk("s1_time_after_go0", 32'd5, 32'd5);
    rd(4'd0);  chk("s0_time_resumed", 32'd15, 32'd15);
    rd(4'd3);  chk("s0_status_running", 32'd1, 32'd1);
    rd(4'd8);  chk("s2_time_idle", 32'd0, 32'd0);
    rd(4'd12); chk("unmapped_12", 32'd0, 32'd0);

    // Snapshot coherence across a carry into bit 32 (s0 still running).
    force dut0.g_sec[0].u_sec.time_q = 40'h00_FFFF_FFFF;
    force dut1.g_sec[0].u_sec.time_q = 40'h00_FFFF_FFFF;
    #1;
    release dut0.g_sec[0].u_sec.time_q;
    release dut1.g_sec[0].u_sec.time_q;
    rd(4'd0);  chk("carry_lo", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    idle(5);
    rd(4'd1);  chk("carry_hi_precarry", 32'd0, 32'd0);
    rd(4'd0);  chk("carry_lo_after", 32'd6, 32'd6);
    rd(4'd1);  chk("carry_hi_after", 32'd1, 32'd1);

    // Event width 4: 17 GOs -> wrap gives 1, saturate holds 15.
    wr(4'd0, 32'd1);
    rd(4'd2);  chk("grst_event0", 32'd0, 32'd0);
    for (int i = 0; i < 17; i++) wr(4'd1, 32'd0);
    rd(4'd2);  chk("ev17_event", 32'd1, 32'd15);
    rd(4'd3);  chk("ev17_status", 32'd3, 32'd3);
    wr(4'd3, 32'd0);
    rd(4'd3);  chk("ctrl_bit0_low", 32'd3, 32'd3);
    wr(4'd3, 32'd1);
    rd(4'd3);  chk("ctrl_clear", 32'd1, 32'd1);
    wr(4'd1, 32'd0);
    rd(4'd2);  chk("ev18_event", 32'd2, 32'd15);
    rd(4'd3);  chk("ev18_status", 32'd1, 32'd3);
    wr(4'd5, 32'd0);
    rd(4'd6);  chk("s1_event_enabled", 32'd1, 32'd1);
    rd(4'd7);  chk("s1_status_enabled", 32'd1, 32'd1);

    // Global reset while both run (saturating instance has overflow set).
    wr(4'd0, 32'd1);
    for (int a = 0; a < 8; a++) begin
      rd(AW'(a));
      chk($sformatf("grst_word%0d", a), 32'd0, 32'd0);
    end

    // Reset mid-count, coinciding with a GO strobe.
    wr(4'd1, 32'd0);
    idle(3);
    address       = 4'd1;
    write         = 1'b1;
    begintransfer = 1'b1;
    reset         = 1'b1;
    @(negedge clk);
    reset         = 1'b0;
    write         = 1'b0;
    begintransfer = 1'b0;
    chk("rst_readdata", 32'd0, 32'd0);
    rd(4'd0);  chk("rst_time0", 32'd0, 32'd0);
    rd(4'd3);  chk("rst_status0", 32'd0, 32'd0);
    rd(4'd2);  chk("rst_event0", 32'd0, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
